// File: rtl/softmax_row_scheduler.sv
// Row scheduler for one softmax core: queues multi-row commands and walks
// each row through init/start/wait, reporting row, command and error events.
module softmax_row_scheduler #(
  parameter int unsigned ADDRSIZE   = 8,
  parameter int unsigned ROWCNT_W   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRSIZE-1:0]  cmd_base,
  input  logic [ADDRSIZE-1:0]  cmd_len,
  input  logic [ADDRSIZE-1:0]  cmd_stride,
  input  logic [ROWCNT_W-1:0]  cmd_rows,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 sm_init,
  output logic                 sm_start,
  output logic [ADDRSIZE-1:0]  sm_start_addr,
  output logic [ADDRSIZE-1:0]  sm_end_addr,
  input  logic                 sm_done,
  output logic                 busy,
  output logic                 row_done,
  output logic                 cmd_done,
  output logic                 err_timeout,
  output logic                 err_range
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = ADDRSIZE + ROWCNT_W + 2;

  typedef struct packed {
    logic [ADDRSIZE-1:0] base;
    logic [ADDRSIZE-1:0] len;
    logic [ADDRSIZE-1:0] stride;
    logic [ROWCNT_W-1:0] rows;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_INIT, S_START, S_WAIT, S_NEXT} state_t;

  state_t               r_state, w_state_nxt;
  cmd_t                 r_fifo [FIFO_DEPTH];
  cmd_t                 w_cmd_in;
  cmd_t                 r_cur;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [ROWCNT_W-1:0]  r_row_idx;
  logic [ROWCNT_W-1:0]  w_rows_m1;
  logic [ADDRSIZE-1:0]  r_row_addr, r_start_addr, r_end_addr, w_row_addr_nxt;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_done_q;
  logic [SUM_W-1:0]     w_extent;
  logic                 w_push, w_pop, w_full, w_empty, w_rise;
  logic                 w_zero, w_range_err, w_timeout, w_last;

  assign w_cmd_in    = {cmd_base, cmd_len, cmd_stride, cmd_rows};
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = cmd_valid & ~w_full & ~abort;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~abort;
  assign w_rise      = sm_done & ~r_done_q;
  assign w_rows_m1   = r_cur.rows - ROWCNT_W'(1);
  assign w_zero      = (r_cur.rows == '0) | (r_cur.len == '0);
  // Full-width extent so a large (rows-1)*stride cannot wrap into range
  assign w_extent    = SUM_W'(r_cur.base) + SUM_W'(w_rows_m1) * SUM_W'(r_cur.stride)
                     + SUM_W'(r_cur.len);
  assign w_range_err = (w_extent > SUM_W'({ADDRSIZE{1'b1}}));
  assign w_timeout   = (timeout_limit != '0) & (r_wdog == timeout_limit);
  assign w_last      = (r_row_idx == w_rows_m1);
  assign w_row_addr_nxt = (r_state == S_NEXT) ? r_row_addr + r_cur.stride : r_row_addr;

  // Next-state and Moore output decode
  always_comb begin
    w_state_nxt = r_state;
    sm_init     = 1'b0;
    sm_start    = 1'b0;
    row_done    = 1'b0;
    cmd_done    = 1'b0;
    err_range   = 1'b0;
    err_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_zero || w_range_err) begin
          w_state_nxt = S_IDLE;
          cmd_done    = 1'b1;
          err_range   = ~w_zero;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        sm_init     = 1'b1;
        w_state_nxt = S_START;
      end
      S_START: begin
        sm_start    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_rise) begin
          w_state_nxt = S_NEXT;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          err_timeout = 1'b1;
          cmd_done    = 1'b1;
        end
      end
      S_NEXT: begin
        row_done    = 1'b1;
        cmd_done    = w_last;
        w_state_nxt = w_last ? S_IDLE : S_INIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      row_done    = 1'b0;
      cmd_done    = 1'b0;
      err_range   = 1'b0;
      err_timeout = 1'b0;
    end
  end

  assign cmd_ready     = ~w_full;
  assign busy          = (r_state != S_IDLE) | ~w_empty;
  assign sm_start_addr = r_start_addr;
  assign sm_end_addr   = r_end_addr;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cur        <= '0;
      r_row_idx    <= '0;
      r_row_addr   <= '0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_wdog       <= '0;
      r_done_q     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= sm_done;
      if (abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_pop) begin
        r_cur      <= r_fifo[r_rd_ptr];
        r_row_idx  <= '0;
        r_row_addr <= r_fifo[r_rd_ptr].base;
      end else if (r_state == S_NEXT) begin
        r_row_idx  <= r_row_idx + ROWCNT_W'(1);
        r_row_addr <= w_row_addr_nxt;
      end
      if (r_state == S_START) begin
        r_wdog <= '0;
      end else if (r_state == S_WAIT && !w_rise) begin
        r_wdog <= r_wdog + TIMEOUT_W'(1);
      end
      // Addresses are loaded on INIT entry so the core sees them during INIT
      if (w_state_nxt == S_INIT) begin
        r_start_addr <= w_row_addr_nxt;
        r_end_addr   <= w_row_addr_nxt + r_cur.len;
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler with a simple latency-driven core model.
module tb_softmax_row_scheduler;

  localparam int unsigned AW = 8;
  localparam int unsigned RW = 8;
  localparam int unsigned TW = 16;

  logic          clk, reset, abort, cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_base, cmd_len, cmd_stride;
  logic [RW-1:0] cmd_rows;
  logic [TW-1:0] timeout_limit;
  logic          sm_init, sm_start, sm_done, busy;
  logic [AW-1:0] sm_start_addr, sm_end_addr;
  logic          row_done, cmd_done, err_timeout, err_range;

  softmax_row_scheduler #(.ADDRSIZE(AW), .ROWCNT_W(RW), .FIFO_DEPTH(4), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride), .cmd_rows(cmd_rows),
    .timeout_limit(timeout_limit),
    .sm_init(sm_init), .sm_start(sm_start),
    .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
    .sm_done(sm_done), .busy(busy),
    .row_done(row_done), .cmd_done(cmd_done),
    .err_timeout(err_timeout), .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Event monitor: counts pulses and logs per-row addresses and times
  int n_init = 0, n_start = 0, n_row = 0, n_cmd = 0, n_rng = 0, n_to = 0;
  int t_row = 0, t_cmd = 0, t_rng = 0, t_to = 0;
  int q_sa[$], q_ea[$], q_ti[$], q_ts[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (sm_init) begin
        n_init++;
        q_sa.push_back(int'(sm_start_addr));
        q_ea.push_back(int'(sm_end_addr));
        q_ti.push_back(cyc);
      end
      if (sm_start)    begin n_start++; q_ts.push_back(cyc); end
      if (row_done)    begin n_row++;   t_row = cyc; end
      if (cmd_done)    begin n_cmd++;   t_cmd = cyc; end
      if (err_range)   begin n_rng++;   t_rng = cyc; end
      if (err_timeout) begin n_to++;    t_to  = cyc; end
    end
  end

  // Core model: done rises core_lat cycles after start, held core_hold cycles
  int core_lat = 4;
  int core_hold = 1;
  initial begin : core_model
    int cnt, hold;
    cnt = -1;
    hold = 0;
    sm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = -1;
        hold = 0;
      end else begin
        if (sm_start) cnt = (core_lat > 0) ? core_lat : -1;
        else if (cnt > 0) cnt--;
        if (cnt == 0) begin
          hold = core_hold;
          cnt = -1;
        end
      end
      sm_done = (hold > 0);
      if (hold > 0) hold--;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Leaves cmd_valid high; caller drops it or drives the next command
  task automatic push(input int b, input int l, input int s, input int r, output int acc);
    int n;
    n = 0;
    cmd_base   = AW'(b);
    cmd_len    = AW'(l);
    cmd_stride = AW'(s);
    cmd_rows   = RW'(r);
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("push_ready_wait", 32'(cmd_ready), 32'd1);
    acc = cyc;
    tick();
  endtask

  task automatic wait_cmd(input int target, input string name);
    int n;
    n = 0;
    while (n_cmd < target && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_cmd_done_seen"}, 32'(n_cmd >= target), 32'd1);
  endtask

  task automatic clear_logs();
    q_sa.delete();
    q_ea.delete();
    q_ti.delete();
    q_ts.delete();
  endtask

  typedef struct {
    int base, len, stride, rows, lat;
    int run, rng;
    int s0, e0, sl, el;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];

  initial begin
    int acc, acc_a, acc_b, n, c0, r0, i0, s0, g0, e0;
    tv[0] = '{'h10, 'h04, 'h08,  3, 20, 3, 0, 'h10, 'h14, 'h20, 'h24};
    tv[1] = '{'h30, 'h04, 'h04,  0,  4, 0, 0, 0, 0, 0, 0};
    tv[2] = '{'h30, 'h00, 'h04,  2,  4, 0, 0, 0, 0, 0, 0};
    tv[3] = '{'hF0, 'h20, 'h00,  1,  4, 0, 1, 0, 0, 0, 0};
    tv[4] = '{'h00, 'h10, 'h10, 16,  4, 0, 1, 0, 0, 0, 0};
    tv[5] = '{'h00, 'h10, 'h10, 15,  2, 15, 0, 'h00, 'h10, 'hE0, 'hF0};
    tv[6] = '{'hEF, 'h11, 'h00,  1,  4, 0, 1, 0, 0, 0, 0};
    tv[7] = '{'hEF, 'h10, 'h00,  1,  3, 1, 0, 'hEF, 'hFF, 'hEF, 'hFF};
    tv[8] = '{'h00, 'h01, 'h80,  3,  4, 0, 1, 0, 0, 0, 0};
    tv[9] = '{'h00, 'h01, 'h80,  2,  3, 2, 0, 'h00, 'h01, 'h80, 'h81};

    reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
    cmd_base = '0; cmd_len = '0; cmd_stride = '0; cmd_rows = '0; timeout_limit = '0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_start", 32'({sm_init, sm_start}), 32'd0);
    check("rst_addrs", 32'({sm_start_addr, sm_end_addr}), 32'd0);
    check("rst_pulses", 32'({row_done, cmd_done, err_timeout, err_range}), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      clear_logs();
      core_lat = tv[i].lat;
      c0 = n_cmd; r0 = n_row; i0 = n_init; s0 = n_start; g0 = n_rng;
      push(tv[i].base, tv[i].len, tv[i].stride, tv[i].rows, acc);
      cmd_valid = 1'b0;
      wait_cmd(c0 + 1, $sformatf("v%0d", i));
      repeat (3) tick();
      check($sformatf("v%0d_inits", i), 32'(n_init - i0), 32'(tv[i].run));
      check($sformatf("v%0d_starts", i), 32'(n_start - s0), 32'(tv[i].run));
      check($sformatf("v%0d_row_done", i), 32'(n_row - r0), 32'(tv[i].run));
      check($sformatf("v%0d_cmd_done", i), 32'(n_cmd - c0), 32'd1);
      check($sformatf("v%0d_err_range", i), 32'(n_rng - g0), 32'(tv[i].rng));
      if (tv[i].run > 0 && q_sa.size() > 0 && q_ts.size() > 0) begin
        check($sformatf("v%0d_start0", i), 32'(q_sa[0]), 32'(tv[i].s0));
        check($sformatf("v%0d_end0", i), 32'(q_ea[0]), 32'(tv[i].e0));
        check($sformatf("v%0d_startN", i), 32'(q_sa[q_sa.size()-1]), 32'(tv[i].sl));
        check($sformatf("v%0d_endN", i), 32'(q_ea[q_ea.size()-1]), 32'(tv[i].el));
        check($sformatf("v%0d_init_lat", i), 32'(q_ti[0] - acc), 32'd3);
        check($sformatf("v%0d_start_lat", i), 32'(q_ts[0] - acc), 32'd4);
        check($sformatf("v%0d_row_lat", i), 32'(t_row - q_ts[q_ts.size()-1]), 32'(tv[i].lat + 1));
      end else begin
        check($sformatf("v%0d_check_done_cyc", i), 32'(t_cmd - acc), 32'd2);
        if (tv[i].rng != 0) check($sformatf("v%0d_rng_with_done", i), 32'(t_rng), 32'(t_cmd));
      end
    end

    // Five back-to-back commands against a slow core
    clear_logs();
    core_lat = 60;
    c0 = n_cmd;
    for (int k = 0; k < 5; k++) push(k * 16, 4, 0, 1, acc);
    cmd_valid = 1'b0;
    check("fifo_full_ready", 32'(cmd_ready), 32'd0);
    check("fifo_full_busy", 32'(busy), 32'd1);
    repeat (20) tick();
    check("fifo_stall_ready", 32'(cmd_ready), 32'd0);
    wait_cmd(c0 + 1, "fifo_first");
    repeat (3) tick();
    check("fifo_ready_after_pop", 32'(cmd_ready), 32'd1);
    wait_cmd(c0 + 5, "fifo_all");
    check("fifo_n_rows", 32'(q_sa.size()), 32'd5);
    for (int k = 0; k < 5 && k < q_sa.size(); k++)
      check($sformatf("fifo_order%0d", k), 32'(q_sa[k]), 32'(k * 16));

    // Watchdog: first command hangs, the queued one must still run
    repeat (2) tick();
    clear_logs();
    timeout_limit = TW'(50);
    core_lat = 0;
    c0 = n_cmd; r0 = n_row; e0 = n_to;
    push('h40, 8, 8, 2, acc_a);
    push('h80, 4, 0, 1, acc_b);
    cmd_valid = 1'b0;
    n = 0;
    while (n_to == e0 && n < 500) begin
      tick();
      n++;
    end
    core_lat = 5;
    check("to_seen", 32'(n_to - e0), 32'd1);
    if (q_ts.size() > 0) check("to_cycle", 32'(t_to - q_ts[0]), 32'd51);
    check("to_with_cmd_done", 32'(t_cmd), 32'(t_to));
    check("to_no_row_done", 32'(n_row - r0), 32'd0);
    wait_cmd(c0 + 2, "to_next");
    check("to_inits", 32'(q_sa.size()), 32'd2);
    if (q_sa.size() == 2) check("to_next_addr", 32'(q_sa[1]), 32'h80);
    check("to_next_row_done", 32'(n_row - r0), 32'd1);
    timeout_limit = '0;

    // Stale done level carried into the next row's WAIT
    repeat (10) tick();
    clear_logs();
    core_lat = 10;
    core_hold = 8;
    c0 = n_cmd; r0 = n_row;
    push('h50, 4, 4, 2, acc);
    cmd_valid = 1'b0;
    wait_cmd(c0 + 1, "stale");
    check("stale_rows", 32'(n_row - r0), 32'd2);
    check("stale_starts", 32'(q_ts.size()), 32'd2);
    if (q_ts.size() == 2) check("stale_row2_lat", 32'(t_row - q_ts[1]), 32'd11);
    core_hold = 1;
    repeat (15) tick();

    // Abort mid-WAIT with a queued command and a simultaneous push
    core_lat = 0;
    s0 = n_start;
    push('h10, 4, 0, 1, acc);
    cmd_valid = 1'b0;
    n = 0;
    while (n_start == s0 && n < 200) begin
      tick();
      n++;
    end
    repeat (5) tick();
    push('h20, 4, 0, 1, acc);
    c0 = n_cmd; r0 = n_row; i0 = n_init; e0 = n_to; g0 = n_rng;
    cmd_base = AW'('h30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (10) tick();
    check("abort_silent", 32'((n_cmd - c0) + (n_row - r0) + (n_to - e0) + (n_rng - g0)), 32'd0);
    check("abort_flushed", 32'(n_init - i0), 32'd0);

    // Asynchronous reset mid-WAIT
    s0 = n_start;
    push('h60, 4, 0, 1, acc);
    cmd_valid = 1'b0;
    n = 0;
    while (n_start == s0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    push('h70, 4, 0, 1, acc);
    cmd_valid = 1'b0;
    check("prerst_busy", 32'(busy), 32'd1);
    check("prerst_addr", 32'(sm_start_addr), 32'h60);
    i0 = n_init;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addrs", 32'({sm_start_addr, sm_end_addr}), 32'd0);
    check("mid_rst_ctl", 32'({sm_init, sm_start, row_done, cmd_done, err_timeout, err_range}), 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_init", 32'(n_init - i0), 32'd0);

    // Normal operation resumes after reset
    clear_logs();
    core_lat = 3;
    c0 = n_cmd;
    push('h08, 2, 0, 1, acc);
    cmd_valid = 1'b0;
    wait_cmd(c0 + 1, "post_rst_cmd");
    check("post_rst_rows", 32'(q_sa.size()), 32'd1);
    if (q_sa.size() == 1) check("post_rst_end", 32'(q_ea[0]), 32'h0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
